// File: rtl/load_store_unit.sv
// Load/store sequencer: turns byte/half/word requests into word reads and
// read-modify-write cycles against a word-wide asynchronous-read memory.
module load_store_unit #(
  parameter int WORD_IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam int ADDR_W = WORD_IDX_W + 2;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         data_q;
  logic [1:0]          size_q;
  logic                we_q;
  logic                uns_q;
  logic                err_q;
  logic                accept;
  logic                req_err;
  logic [4:0]          lane_shift;
  logic [31:0]         store_merge;
  logic [31:0]         load_ext;

  assign req_ready  = (state == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign lane_shift = {addr_q[1:0], 3'b000};

  // Classify the incoming request as misaligned, illegal size or out of range
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr[31:ADDR_W] != '0) req_err = 1'b1;
  end

  // Next-state selection: errors skip memory, word stores skip the read
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                 state_next = RESP;
          else if (!req_we)            state_next = READ;
          else if (req_size == 2'b10)  state_next = WRITE;
          else                         state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus request capture at accept and read-data capture in READ
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
      end
      if (state == READ) data_q <= mem_RD;
    end
  end

  // Merge the store lane(s) into the previously read word
  always_comb begin
    store_merge = data_q;
    if (size_q == 2'b00)
      store_merge[lane_shift +: 8] = wdata_q[7:0];
    else if (addr_q[1])
      store_merge[31:16] = wdata_q[15:0];
    else
      store_merge[15:0] = wdata_q[15:0];
  end

  // Pick the load lane and sign- or zero-extend it
  always_comb begin
    load_ext = data_q;
    case (size_q)
      2'b00: begin
        load_ext = {24'b0, data_q[lane_shift +: 8]};
        if (!uns_q && load_ext[7]) load_ext[31:8] = '1;
      end
      2'b01: begin
        load_ext = addr_q[1] ? {16'b0, data_q[31:16]} : {16'b0, data_q[15:0]};
        if (!uns_q && load_ext[15]) load_ext[31:16] = '1;
      end
      default: load_ext = data_q;
    endcase
  end

  // Memory and response outputs, all zero outside their active states
  always_comb begin
    mem_WE     = 1'b0;
    mem_A      = '0;
    mem_WD     = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (state == READ || state == WRITE)
      mem_A = {{(32-WORD_IDX_W){1'b0}}, addr_q[ADDR_W-1:2]};
    if (state == WRITE) begin
      mem_WE = !rst;
      mem_WD = (size_q == 2'b10) ? wdata_q : store_merge;
    end
    if (state == RESP) begin
      resp_valid = 1'b1;
      resp_err   = err_q;
      if (!err_q && !we_q) resp_rdata = load_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int          checks = 0;
  int          failures = 0;
  int          we_count = 0;
  int          cyc = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  load_store_unit #(.WORD_IDX_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_RD(mem_RD)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Data_Mem stand-in: asynchronous read, write on the rising edge
  assign mem_RD = mem[mem_A[7:0]];
  always @(posedge clk) if (mem_WE) mem[mem_A[7:0]] <= mem_WD;

  // Cycle counter and write monitor sampled mid-cycle
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_WE) begin
      we_count = we_count + 1;
      last_wa  = mem_A;
      last_wd  = mem_WD;
    end
  end

  function automatic logic is_err_f(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd1024);
  endfunction

  function automatic logic [31:0] load_f(input logic [31:0] word, input logic [1:0] size,
                                         input int off, input logic uns);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (word >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_f(input logic [31:0] old, input logic [1:0] size,
                                          input int off, input logic [31:0] wd);
    logic [31:0] mask;
    if (size == 2'd0) begin
      mask = 32'hFF << (8 * off);
      return (old & ~mask) | ((wd & 32'hFF) << (8 * off));
    end else if (size == 2'd1) begin
      mask = 32'hFFFF << (16 * (off / 2));
      return (old & ~mask) | ((wd & 32'hFFFF) << (16 * (off / 2)));
    end
    return wd;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its response and check it against the model
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat, lat, wc0, idx;
    @(negedge clk);
    checkOutput("ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    wc0 = we_count;
    idx = int'(addr[9:2]);
    exp_err = is_err_f(size, addr);
    exp_lat = exp_err ? 1 : ((we && size != 2'd2) ? 3 : 2);
    exp_rdata = (exp_err || we) ? 32'd0 : load_f(ref_mem[idx], size, int'(addr % 4), uns);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom; req_we = 1'($urandom);
    lat = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (resp_valid) begin lat = n; break; end
    end
    checkOutput("latency", lat, exp_lat);
    checkOutput("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
    checkOutput("resp_rdata", resp_rdata, exp_rdata);
    if (!exp_err && we) begin
      ref_mem[idx] = store_f(ref_mem[idx], size, int'(addr % 4), wdata);
      checkOutput("write_addr", last_wa, idx);
      checkOutput("write_data", last_wd, ref_mem[idx]);
    end
    checkOutput("write_count", we_count - wc0, (!exp_err && we) ? 1 : 0);
    checkOutput("mem_word", mem[idx], ref_mem[idx]);
  endtask

  // Directed plan followed by random traffic and a back-to-back burst
  initial begin
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int          wc0, nreq, last_acc, extra, mism, r;

    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_WE}, 32'd0);
    checkOutput("rst_mem_a", mem_A, 32'd0);
    checkOutput("rst_mem_wd", mem_WD, 32'd0);
    rst = 1'b0;

    $display("[TB] word store/load");
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    $display("[TB] byte read-modify-write");
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h04, 32'h11223344);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h06, 32'h000000AA);
    checkOutput("byte_rmw_word", mem[1], 32'h11AA3344);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h06, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h06, 32'h0);

    $display("[TB] half access");
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0A, 32'h00008001);
    checkOutput("half_word", mem[2], 32'h80010000);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0);

    $display("[TB] error cases");
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h02, 32'h0);
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h00, 32'hCAFE);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h400, 32'h5555AAAA);

    $display("[TB] reset during write");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h04; req_wdata = 32'h55;
    wc0 = we_count;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_mem_we", {31'b0, mem_WE}, 32'd0);
    checkOutput("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_ready", {31'b0, req_ready}, 32'd1);
    extra = 0;
    for (int n = 0; n < 3; n++) begin
      if (resp_valid) extra++;
      @(negedge clk);
    end
    checkOutput("rstmid_no_resp", extra, 0);
    checkOutput("rstmid_writes", we_count - wc0, 0);
    checkOutput("rstmid_word1", mem[1], ref_mem[1]);

    $display("[TB] random traffic");
    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h400 << $urandom_range(0, 21));
      applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("[TB] back-to-back word store/load");
    nreq = 0; last_acc = -1; extra = 0; wc0 = we_count; a = '0; wd = '0;
    for (int t = 0; t < 80 && (nreq < 8 || exp_q.size() > 0); t++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          checkOutput("b2b_rdata", resp_rdata, e[31:0]);
          checkOutput("b2b_err", {31'b0, resp_err}, {31'b0, e[32]});
        end
      end
      if (req_ready && nreq < 8) begin
        if (last_acc >= 0) checkOutput("b2b_interval", cyc - last_acc, 3);
        last_acc = cyc;
        req_valid = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        if (nreq % 2 == 0) begin
          a  = 32'(4 * $urandom_range(16, 31));
          wd = $urandom;
          req_we = 1'b1; req_addr = a; req_wdata = wd;
          ref_mem[a[9:2]] = wd;
          exp_q.push_back({1'b0, 32'd0});
        end else begin
          req_we = 1'b0; req_addr = a;
          exp_q.push_back({1'b0, ref_mem[a[9:2]]});
        end
        nreq++;
      end else begin
        req_wdata = $urandom;
        if (nreq >= 8) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b_issued", nreq, 8);
    checkOutput("b2b_pending", exp_q.size(), 0);
    checkOutput("b2b_extra", extra, 0);
    checkOutput("b2b_writes", we_count - wc0, 4);

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    checkOutput("mem_final", mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store sequencer between the datapath (ALU address, register-file store data) and the word-wide `Data_Mem`. It accepts one memory request at a time and converts byte and halfword accesses into word reads and read-modify-write cycles against the 256-word array. It returns sign- or zero-extended load data for writeback, and flags misaligned or out-of-range accesses without touching memory.

## Interface
- `WORD_IDX_W`, 8: width of the word index; addressable range is bytes 0 .. 4·2^WORD_IDX_W − 1.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE and while `rst` is low.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; bits [7:0] are used for byte, [15:0] for half.
- `resp_valid` out 1: one-cycle completion pulse, for both loads and stores.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; 1 means misaligned, illegal size or out of range.
- `mem_WE` out 1: write enable to `Data_Mem`.
- `mem_A` out 32: word index to `Data_Mem`, equal to {zeros, addr[WORD_IDX_W+1:2]}.
- `mem_WD` out 32: write data to `Data_Mem`.
- `mem_RD` in 32: asynchronous read data from `Data_Mem`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Accept: a request is accepted on a rising edge where `req_valid && req_ready`. At that edge the unit latches addr, size, we, unsigned and wdata. Inputs are ignored in every other state.
- Error check at accept:
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - size = 11;
  - addr[31:WORD_IDX_W+2] ≠ 0.
  - Any of these: go to RESP with err = 1. No memory access.
- Transitions from IDLE:
  - load → READ;
  - word store → WRITE;
  - byte or half store → READ.
- READ:
  - drive `mem_A` and register `mem_RD` into the data register;
  - next state is RESP for a load, WRITE for a store.
- WRITE:
  - `mem_WE` = 1;
  - `mem_WD` = latched wdata for a word store;
  - for a sub-word store, `mem_WD` = data register with the target lane(s) replaced by the store data;
  - next state is RESP.
- RESP: `resp_valid` = 1 for one cycle, then IDLE. There is no response backpressure.
- Lanes are little-endian: byte k (addr[1:0] = k) occupies bits [8k+7:8k]; a half at addr[1] = h occupies bits [16h+15:16h].
- Load extraction: select the lane from the data register, then sign- or zero-extend to 32 bits. A word load returns the register unchanged. `resp_rdata` is held 0 outside RESP.
- `mem_A` is driven from the latched address in READ and WRITE, and is 0 in IDLE and RESP.
- `mem_WD` is 0 outside WRITE.

## Timing
- Reset values: state IDLE, `req_ready` 0 during reset, `resp_valid` 0, `resp_err` 0, `resp_rdata` 0, `mem_WE` 0, `mem_A` 0, `mem_WD` 0, data register 0.
- Latency, counted from the accept edge (cycle 0) to the `resp_valid` cycle:
  - load: READ in cycle 1, RESP in cycle 2;
  - word store: WRITE in cycle 1, RESP in cycle 2;
  - sub-word store: READ in cycle 1, WRITE in cycle 2, RESP in cycle 3;
  - error: RESP in cycle 1.
- Back-to-back throughput: `req_ready` rises in the cycle after RESP. The minimum issue interval is therefore 3 cycles for loads and word stores, and 4 for sub-word stores.
- Exactly one `mem_WE` cycle per successful store; zero for loads and errors.
- Reset mid-operation:
  - `mem_WE` is gated by `!rst` combinationally, so no write occurs in a cycle where `rst` = 1;
  - the in-flight request is dropped with no `resp_valid`;
  - the state is IDLE after the edge.
- Store data is captured at accept; later changes on `req_wdata` do not affect the write.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x10, then load the word at 0x10. Required: `mem_WE` one cycle with `mem_A` = 4 and `mem_WD` = 0xDEADBEEF; load returns 0xDEADBEEF in cycle 2.
- Byte RMW: memory word 1 = 0x11223344; store byte 0xAA at 0x06 → word 1 becomes 0x11AA3344. Then:
  - signed byte load at 0x06 returns 0xFFFFFFAA;
  - unsigned byte load returns 0x000000AA.
- Half access: store half 0x8001 at 0x0A into word 2 = 0. Required: word 2 becomes 0x80010000, signed half load returns 0xFFFF8001, unsigned returns 0x00008001.
- Errors, each giving `resp_err` = 1 in cycle 1, `resp_rdata` = 0, no `mem_WE`, memory unchanged:
  - half store at 0x03;
  - word load at 0x02;
  - size 11;
  - addr 0x400.
- Reset mid-operation: assert `rst` during the WRITE cycle of a byte store to 0x04. Required: `mem_WE` stays 0, word 1 is unchanged, no `resp_valid`, and `req_ready` = 1 in the first cycle after `rst` deasserts.
- Back-to-back with wdata change: hold `req_valid` high with alternating word store and load. Required:
  - `req_ready` pulses every 3 cycles;
  - no request is lost or duplicated;
  - changing `req_wdata` after accept does not alter the stored value.
